sll_pipe: RTL

- Pipelined 32-bit logical shift-left unit; the left-shift counterpart to the ALU's structural logical shift-right path.
- Five register stages. Stage k shifts by 2^k when shift-amount bit k is set.
- Valid/ready handshake on both sides. Sustains one result per cycle and stalls cleanly under backpressure.
- Sits between the ALU issue logic and the writeback arbiter. A tag is carried through for result routing.

---
 rtl/sll_pipe_if.sv | 27 ++
 rtl/sll_pipe.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sll_pipe_if.sv
// Issue-side and writeback-side handshake bundle for the pipelined shift-left unit.
// The unit itself connects through the slave modport; the issuing agent uses master.
interface sll_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sll_res;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       in_flight;

  modport master (
    output in_valid, operand_a, operand_b, in_tag, out_ready,
    input  in_ready, out_valid, sll_res, out_tag, in_flight
  );

  modport slave (
    input  in_valid, operand_a, operand_b, in_tag, out_ready,
    output in_ready, out_valid, sll_res, out_tag, in_flight
  );
endinterface

// File: rtl/sll_pipe.sv
// Pipelined logical shift-left: stage s shifts by 2**s when bit s of the amount is set.
// Elastic valid/ready pipeline with a combinational ready chain and a tag carried alongside.

module sll_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int TAG_W = 4,
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic [SHW-1:0]   up_sh,
  input  logic [TAG_W-1:0] up_tag,
  output logic             v_d,
  output logic             v_q,
  output logic [WIDTH-1:0] d_q,
  output logic [SHW-1:0]   sh_q,
  output logic [TAG_W-1:0] t_q
);
  localparam int AMT = 1 << STAGE;

  logic [WIDTH-1:0] d_d;
  logic [SHW-1:0]   sh_d;
  logic [TAG_W-1:0] t_d;

  always_comb begin
    // NOTE: every output gets a hold default first so no path leaves a latch.
    v_d  = v_q;
    d_d  = d_q;
    sh_d = sh_q;
    t_d  = t_q;
    if (load) begin
      v_d  = up_valid;
      sh_d = up_sh;
      t_d  = up_tag;
      d_d  = up_sh[STAGE] ? (up_data << AMT) : up_data;
    end
  end

  // NOTE: data/tag flops are reset too, so sll_res and out_tag read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= 1'b0;
      d_q  <= '0;
      sh_q <= '0;
      t_q  <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its upstream's pre-edge value.
      v_q  <= v_d;
      d_q  <= d_d;
      sh_q <= sh_d;
      t_q  <= t_d;
    end
  end
endmodule

module sll_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int TAG_W = 4
) (
  input logic     clk,
  input logic     rst_n,
  sll_pipe_if.slave bus
);
  localparam int STAGES = SHW;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_nxt;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  d  [STAGES];
  logic [SHW-1:0]    sh [STAGES];
  logic [TAG_W-1:0]  t  [STAGES];
  logic [2:0]        in_flight_d;
  logic [2:0]        in_flight_q;

  // A stage can move when it or any stage downstream of it has a bubble, or the sink drains.
  always_comb begin
    rdy = '0;
    for (int s = 0; s < STAGES; s++) begin
      rdy[s] = bus.out_ready;
      for (int j = s; j < STAGES; j++) begin
        if (!v[j]) rdy[s] = 1'b1;
      end
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic [SHW-1:0]   up_sh;
    logic [TAG_W-1:0] up_t;

    if (s == 0) begin : g_src
      assign up_v  = bus.in_valid;
      assign up_d  = bus.operand_a;
      assign up_sh = bus.operand_b[SHW-1:0];
      assign up_t  = bus.in_tag;
    end else begin : g_chain
      assign up_v  = v[s-1];
      assign up_d  = d[s-1];
      assign up_sh = sh[s-1];
      assign up_t  = t[s-1];
    end

    sll_pipe_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .TAG_W (TAG_W),
      .STAGE (s)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (rdy[s]),
      .up_valid (up_v),
      .up_data  (up_d),
      .up_sh    (up_sh),
      .up_tag   (up_t),
      .v_d      (v_nxt[s]),
      .v_q      (v[s]),
      .d_q      (d[s]),
      .sh_q     (sh[s]),
      .t_q      (t[s])
    );
  end

  // Occupancy is registered from the next-state valids so it tracks popcount(v) exactly.
  always_comb begin
    in_flight_d = '0;
    for (int s = 0; s < STAGES; s++) begin
      in_flight_d = in_flight_d + 3'(v_nxt[s]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight_q <= '0;
    end else begin
      in_flight_q <= in_flight_d;
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v[STAGES-1];
  assign bus.sll_res   = d[STAGES-1];
  assign bus.out_tag   = t[STAGES-1];
  assign bus.in_flight = in_flight_q;

  // Upper amount bits are architecturally ignored; the last stage's shift field has no consumer.
  logic unused_bits;
  assign unused_bits = ^{bus.operand_b[WIDTH-1:SHW], sh[STAGES-1]};

  a_out_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.sll_res) && $stable(bus.out_tag)));

  a_flight_count : assert property (@(posedge clk) disable iff (!rst_n)
    in_flight_q == 3'($countones(v)));
endmodule
